// File: rtl/button_debouncer_array.sv
// Per-channel button debouncer: 2-flop synchronizer, stability-window filter, rise/fall pulses.
// Optional long-press pulse per channel, compiled in when LONG_PRESS_EN is defined.
module button_debouncer_array #(
   parameter int N_CH     = 4,
   parameter int CNT_MAX  = 240000,
   parameter int HOLD_MAX = 12000000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] noisy,
   output logic [N_CH-1:0] clean,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] long_press
);
   localparam int CW = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   logic [N_CH-1:0] sync1_q, sync2_q;
   logic [N_CH-1:0] clean_q, clean_d;
   logic [N_CH-1:0] rise_q, rise_d;
   logic [N_CH-1:0] fall_q, fall_d;
   logic [CW-1:0]   cnt_q [N_CH];
   logic [CW-1:0]   cnt_d [N_CH];

   // The counter only runs while the synchronized input disagrees with the debounced level.
   always_comb begin
      clean_d = clean_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != clean_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               clean_d[i] = sync2_q[i];
               rise_d[i]  = sync2_q[i];
               fall_d[i]  = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         clean_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= noisy;
         sync2_q <= sync1_q;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign clean = clean_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

`ifdef LONG_PRESS_EN
   localparam int HW = ($clog2(HOLD_MAX) < 1) ? 1 : $clog2(HOLD_MAX);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

   logic [HW-1:0]   hold_q [N_CH];
   logic [HW-1:0]   hold_d [N_CH];
   logic [N_CH-1:0] fired_q, fired_d;
   logic [N_CH-1:0] long_press_q, long_press_d;

   // fired blocks repeat pulses until the button is released.
   always_comb begin
      fired_d      = fired_q;
      long_press_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         hold_d[i] = hold_q[i];
         if (!clean_q[i]) begin
            hold_d[i]  = '0;
            fired_d[i] = 1'b0;
         end else if (!fired_q[i]) begin
            if (hold_q[i] == HOLD_LAST) begin
               long_press_d[i] = 1'b1;
               fired_d[i]      = 1'b1;
            end else begin
               hold_d[i] = hold_q[i] + HW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fired_q      <= '0;
         long_press_q <= '0;
         for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
      end else begin
         fired_q      <= fired_d;
         long_press_q <= long_press_d;
         for (int i = 0; i < N_CH; i++) hold_q[i] <= hold_d[i];
      end
   end

   assign long_press = long_press_q;
`else
   // HOLD_MAX is referenced only to keep the parameter live; legal values give all zeros.
   assign long_press = {N_CH{HOLD_MAX < 2}};
`endif

endmodule

// File: tb/tb_button_debouncer_array.sv
// Scoreboard bench for button_debouncer_array (N_CH=2, CNT_MAX=4, HOLD_MAX=10).
// Reference model: a level flips once the input seen two edges late has disagreed with it for CNT_MAX edges.
module tb_button_debouncer_array;
   localparam int N  = 2;
   localparam int CM = 4;
   localparam int HM = 10;

   typedef logic [4*N-1:0] vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] noisy = '0;
   logic [N-1:0] clean, rise, fall, long_press;

   always #5 clk = ~clk;

   button_debouncer_array #(.N_CH(N), .CNT_MAX(CM), .HOLD_MAX(HM)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .noisy      (noisy),
      .clean      (clean),
      .rise       (rise),
      .fall       (fall),
      .long_press (long_press)
   );

   vec_t         exp_q[$];
   int           vectors = 0;
   int           miscompares = 0;
   int           cyc = 0;
   bit           hist [N][CM+2];
   logic [N-1:0] clean_m = '0;
   int           rise_at [N];

   // Reference model: hist[ch][j] is the raw input sampled j edges ago.
   always @(posedge clk) begin
      logic [N-1:0] r, f, lp;
      bit all_diff;
      cyc++;
      r  = '0;
      f  = '0;
      lp = '0;
      if (!rst_n) begin
         for (int ch = 0; ch < N; ch++)
            for (int j = 0; j < CM + 2; j++) hist[ch][j] = 1'b0;
         clean_m = '0;
      end else begin
         for (int ch = 0; ch < N; ch++) begin
            for (int j = CM + 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
            hist[ch][0] = noisy[ch];
`ifdef LONG_PRESS_EN
            if (clean_m[ch] && (cyc - rise_at[ch] == HM)) lp[ch] = 1'b1;
`endif
            all_diff = 1'b1;
            for (int j = 2; j < CM + 2; j++)
               if (hist[ch][j] == clean_m[ch]) all_diff = 1'b0;
            if (all_diff) begin
               clean_m[ch] = ~clean_m[ch];
               if (clean_m[ch]) begin
                  r[ch]       = 1'b1;
                  rise_at[ch] = cyc;
               end else begin
                  f[ch] = 1'b1;
               end
            end
         end
      end
      exp_q.push_back({lp, f, r, clean_m});
   end

   // Monitor: every cycle the DUT presents a full output vector.
   always @(posedge clk) begin
      vec_t e, a;
      #1;
      a = {long_press, fall, rise, clean};
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty cyc=%0d got %b", cyc, a);
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL out_vec cyc=%0d lp/fall/rise/clean got %b expected %b", cyc, a, e);
         end
      end
   end

   task automatic apply(input logic [N-1:0] v, input int n);
      noisy = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int hold;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // single channel press
      apply(2'b01, 10);
      // glitch of 3 cycles is filtered, 4 cycles is accepted
      apply(2'b00, 3);
      apply(2'b01, 8);
      apply(2'b00, 4);
      apply(2'b00, 6);
      apply(2'b01, 10);
      apply(2'b00, 10);
      // bouncing channel 1
      for (int t = 0; t < 10; t++) apply({~noisy[1], noisy[0]}, 2);
      apply(2'b10, 10);
      // simultaneous transitions
      apply(2'b00, 8);
      apply(2'b11, 8);
      apply(2'b01, 8);
      // long presses
      apply(2'b00, 8);
      apply(2'b01, 25);
      apply(2'b00, 8);
      apply(2'b01, 25);
      apply(2'b00, 8);
      // reset mid-count
      apply(2'b01, 4);
      pulse_reset();
      apply(2'b01, 10);
      // randomized segments with occasional resets and long holds
      for (int s = 0; s < 300; s++) begin
         if ($urandom_range(0, 39) == 0) pulse_reset();
         hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 30))
                                            : int'($urandom_range(1, 7));
         apply(N'($urandom_range(0, (1 << N) - 1)), hold);
      end
      apply(2'b00, 10);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
